// File: rtl/perf_counter_bank.sv
// perf_counter_bank: N_CH saturating event counters that freeze on halt, plus a looping
// double-dabble converter presenting the selected channel as packed BCD. PERF_SEG7_EN adds seg.

module perf_cnt_lane #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_ev,
  output logic [CW-1:0] o_cnt,
  output logic          o_ovf
);
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  // Saturating: at all-ones the count holds and the sticky flag latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_en && i_ev) begin
      if (&r_cnt) r_ovf <= 1'b1;
      else        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
endmodule

module perf_counter_bank #(
  parameter  int N_CH   = 4,
  parameter  int CW     = 32,
  parameter  int DIGITS = 6,
  localparam int SW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       ev,
  input  logic                  halt,
  input  logic                  clear,
  input  logic [SW-1:0]         sel,
  output logic                  running,
  output logic [N_CH-1:0]       overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [SW-1:0]         bcd_sel,
  output logic                  bcd_valid
`ifdef PERF_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg
`endif
);
  // Internal BCD register holds every decimal digit a CW-bit value can need.
  localparam int NBD = ((CW + 2) / 3 > DIGITS) ? (CW + 2) / 3 : DIGITS;
  localparam int BW  = 4 * NBD;
  localparam int CBW = $clog2(CW + 1);

  typedef enum logic {RS_RUN, RS_DONE} run_t;
  typedef enum logic [1:0] {CV_LOAD, CV_SHIFT, CV_DONE} cv_t;

  run_t                   r_run_st;
  cv_t                    r_cv_st;
  logic [N_CH-1:0][CW-1:0] w_cnt;
  logic                   w_cnt_en;
  logic [SW-1:0]          w_sel_eff;
  logic [CW-1:0]          w_sel_val;
  logic [CW-1:0]          r_snap;
  logic [SW-1:0]          r_snap_sel;
  logic [BW-1:0]          r_sh;
  logic [BW-1:0]          w_adj;
  logic [CBW-1:0]         r_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_st <= RS_RUN;
      running  <= 1'b1;
    end else if (clear) begin
      r_run_st <= RS_RUN;
      running  <= 1'b1;
    end else if (r_run_st == RS_RUN && halt) begin
      r_run_st <= RS_DONE;
      running  <= 1'b0;
    end
  end

  // Events in the halt cycle still count; freezing starts on the following edge.
  assign w_cnt_en = (r_run_st == RS_RUN);

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    perf_cnt_lane #(.CW(CW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_cnt_en),
      .i_clr (clear),
      .i_ev  (ev[g]),
      .o_cnt (w_cnt[g]),
      .o_ovf (overflow[g])
    );
  end

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    w_sel_eff = '0;
    w_sel_val = w_cnt[0];
    for (int i = 1; i < N_CH; i++) begin
      if (sel == SW'(i)) begin
        w_sel_eff = SW'(i);
        w_sel_val = w_cnt[i];
      end
    end
  end

  always_comb begin
    w_adj = r_sh;
    for (int d = 0; d < NBD; d++)
      if (r_sh[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_sh[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cv_st    <= CV_LOAD;
      r_snap     <= '0;
      r_snap_sel <= '0;
      r_sh       <= '0;
      r_bit      <= '0;
      bcd        <= '0;
      bcd_sel    <= '0;
      bcd_valid  <= 1'b0;
    end else begin
      case (r_cv_st)
        CV_LOAD: begin
          r_snap     <= w_sel_val;
          r_snap_sel <= w_sel_eff;
          r_sh       <= '0;
          r_bit      <= '0;
          r_cv_st    <= CV_SHIFT;
        end
        CV_SHIFT: begin
          r_sh   <= BW'({w_adj, r_snap[CW-1]});
          r_snap <= r_snap << 1;
          r_bit  <= r_bit + 1'b1;
          if (r_bit == CBW'(CW - 1)) r_cv_st <= CV_DONE;
        end
        CV_DONE: begin
          bcd       <= r_sh[4*DIGITS-1:0];
          bcd_sel   <= r_snap_sel;
          bcd_valid <= 1'b1;
          r_cv_st   <= CV_LOAD;
        end
        default: r_cv_st <= CV_LOAD;
      endcase
    end
  end

`ifdef PERF_SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic w_seen;

  // Blank zeros above the most significant nonzero digit; digit 0 always lit.
  always_comb begin
    seg    = '1;
    w_seen = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (bcd[4*k +: 4] != 4'd0) w_seen = 1'b1;
      if (w_seen || k == 0) seg[7*k +: 7] = seg7(bcd[4*k +: 4]);
    end
  end
`endif
endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised successor to the single free-running cycle counter in the FPGA top level.
- Holds N_CH independent event counters (cycles, retired instrs, stalls, flushes, ...) that run from reset until the core halts on ebreak.
- A sequential double-dabble converter turns the selected channel into DIGITS packed-BCD digits for the HEX displays. No combinational divide/modulo chain.
- Sits beside riscvpipeline in top; event strobes come from the core, halt from ebreak detection.

Parameters:
- N_CH, 4, number of counter channels (1..8)
- CW, 32, counter width in bits (4..32)
- DIGITS, 6, decimal digits presented on bcd (1..8)

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high reset
- ev  in  N_CH  per-channel increment strobe, sampled each clk
- halt  in  1  program finished (ebreak seen); level or pulse
- clear  in  1  synchronous clear of counters/overflow; restarts counting
- sel  in  max(1,$clog2(N_CH))  channel to display
- running  out  1  1 while counters are enabled
- overflow  out  N_CH  sticky per-channel saturation flag
- bcd  out  4*DIGITS  packed BCD of last converted value, digit 0 in [3:0]
- bcd_sel  out  max(1,$clog2(N_CH))  channel that bcd belongs to
- bcd_valid  out  1  1 once at least one conversion has completed since reset

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - all counters 0, overflow 0, running 1 (run state RUN)
  - bcd 0, bcd_sel 0, bcd_valid 0, converter in LOAD
- Run FSM: RUN, DONE.
  - RUN to DONE on halt=1. DONE is absorbing; further halt or ev have no effect.
  - clear=1 in any state: counters 0, overflow 0, next state RUN. clear beats halt in the same cycle.
  - running = (state==RUN).
- Counting, per channel i, on each clk with state==RUN and no clear:
  - ev[i]=1 and cnt[i]!=2^CW-1: cnt[i]+1.
  - ev[i]=1 and cnt[i]==2^CW-1: hold, set overflow[i]. Saturate, never wrap.
  - ev[i] in the halt cycle is counted. Counters freeze from the next cycle.
- Converter FSM: LOAD, SHIFT, DONE. It loops continuously.
  - LOAD (1 cycle): snapshot cnt[sel] and sel. Clear the BCD shift register.
  - SHIFT (CW cycles): add 3 to each BCD nibble >=5, then shift left one bit, taking the MSB of the snapshot.
  - DONE (1 cycle): bcd <= result mod 10^DIGITS, bcd_sel <= snapshot sel, bcd_valid <= 1. Then go to LOAD.
  - Conversion period is exactly CW+2 cycles. bcd reflects a counter value no older than 2*(CW+2) cycles.
  - bcd/bcd_sel change only in DONE and are otherwise held stable.
- Boundaries:
  - sel changes mid-conversion: the current conversion completes with the old snapshot. The new sel is taken at the next LOAD.
  - clear mid-conversion: the converter is not aborted. The next LOAD sees 0.
  - Value >= 10^DIGITS: only the low DIGITS decimal digits are shown. Internal BCD register is sized for full CW.
  - sel >= N_CH: treated as channel 0.

Optional Feature:
- Macro PERF_SEG7_EN.
- Defined:
  - adds output seg, 7*DIGITS bits, active-low segments (HEX display polarity), digit k in [7k+6:7k]
  - decoded combinationally from registered bcd
  - leading-zero blanking: zero digits above the most significant nonzero digit are blank (all 1s); digit 0 is always shown
- Not defined: no seg port and no decode logic. top keeps its external hex7seg instances.

Test Plan:
- Reset, ev=4'b0001 every cycle, halt pulse on the 100th cycle after reset release -> cnt[0]=100, running=0. With sel=0, after <=2*(CW+2) cycles: bcd=24'h000100, bcd_valid=1, bcd_sel=0.
- CW=8 instance, ev[2] held for 300 cycles -> cnt[2]=255, overflow[2]=1 from the 256th event on, overflow[0,1,3]=0. sel=2 gives bcd=24'h000255.
- Drive ev[0]=1 and ev[1] every other cycle. Toggle sel 0->1 during SHIFT -> the first DONE still reports bcd_sel=0 with the old value. The following DONE reports bcd_sel=1 with cnt[1].
- clear and halt asserted in the same cycle while in RUN -> all counters 0, overflow 0, running=1. Counting resumes on the next ev.
- Assert reset asynchronously mid-SHIFT (between clk edges) -> bcd=0, bcd_valid=0, counters 0 before any clk edge. First DONE occurs exactly CW+2 cycles after release.
- DIGITS=6, 1234567 ev[3] strobes, sel=3 -> bcd=24'h234567. With PERF_SEG7_EN and count 42: digits 2..5 blank (7'h7F), digit 1 shows "4", digit 0 shows "2".
